// File: rtl/scp_pkg.sv
// Shared constants for the SCP IO hub: status word bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package scp_pkg;

   // Bit positions inside the status word returned by IOS
   localparam int ST_TXE = 0;   // TX FIFO empty
   localparam int ST_TXF = 1;   // TX FIFO full
   localparam int ST_RXF = 2;   // RX holding register full
   localparam int ST_OVF = 3;   // sticky: write to a full TX FIFO
   localparam int ST_UNF = 4;   // sticky: read of an empty RX register
   localparam int ST_W   = 5;

endpackage : scp_pkg

// File: rtl/scp_sync_fifo.sv
// Single-clock FIFO with registered storage; head is the oldest entry.
// Latency: push visible at head/empty one cycle after the edge.
// Backpressure: push while full is dropped; pop while empty is ignored.
module scp_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          do_push, do_pop;

   // Full/empty come from the count sampled before the edge, so a pop never frees room for a same-cycle push
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Next-state: write at wr_ptr, advance pointers with natural wrap, track occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   // State registers; reset discards all buffered entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule : scp_sync_fifo

// File: rtl/scp_io_hub.sv
// NCH byte channels on the SCP bus: TX FIFO per channel, one-entry RX register, sticky ovf/unf flags.
// Latency: IOW->TX_VALID 1 cycle, RX capture->readable 1 cycle, bus reads combinational.
// Backpressure: TX holds head while TX_READY low; RX_READY low while holding register is full.
module scp_io_hub
   import scp_pkg::*;
#(
   parameter int BUS_W    = 16,
   parameter int DW       = 8,
   parameter int NCH      = 4,
   parameter int TX_DEPTH = 4
) (
   input  logic                    CLK,
   input  logic                    AR,
   input  logic                    IOR,
   input  logic                    IOW,
   input  logic                    IOS,
   input  logic [$clog2(NCH)-1:0]  CH_SEL,
   input  logic [BUS_W-1:0]        DATA_IN,
   output logic [BUS_W-1:0]        DATA_OUT,
   output logic                    DATA_OE,
   output logic [NCH*DW-1:0]       TX_DATA,
   output logic [NCH-1:0]          TX_VALID,
   input  logic [NCH-1:0]          TX_READY,
   input  logic [NCH*DW-1:0]       RX_DATA,
   input  logic [NCH-1:0]          RX_VALID,
   output logic [NCH-1:0]          RX_READY,
   output logic                    IRQ
);

   localparam int CSW = $clog2(NCH);

   logic [NCH-1:0]  sel;
   logic            rd_stb, st_stb;
   logic [NCH-1:0]  tx_full, tx_empty, tx_push, tx_pop;
   logic [DW-1:0]   tx_head [NCH];
   logic [DW-1:0]   rx_data_q [NCH];
   logic [DW-1:0]   rx_data_d [NCH];
   logic [NCH-1:0]  rx_full_q, rx_full_d;
   logic [NCH-1:0]  ovf_q, ovf_d;
   logic [NCH-1:0]  unf_q, unf_d;
   logic [DW-1:0]   rd_byte;
   logic [ST_W-1:0] status;

   // One-hot channel decode of CH_SEL
   always_comb begin
      sel = '0;
      for (int c = 0; c < NCH; c++) begin
         sel[c] = (CH_SEL == CSW'(c));
      end
   end

   // IOR has priority: a combined IOR+IOS is a plain read and leaves the flags alone
   assign rd_stb   = IOR;
   assign st_stb   = IOS & ~IOR;
   assign tx_push  = {NCH{IOW}} & sel;
   assign tx_pop   = TX_READY & ~tx_empty;
   assign TX_VALID = ~tx_empty;
   assign RX_READY = ~rx_full_q;
   assign IRQ      = |(rx_full_q | ovf_q | unf_q);

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_tx
         scp_sync_fifo #(.W(DW), .DEPTH(TX_DEPTH)) u_fifo (
            .clk   (CLK),
            .rst   (AR),
            .push  (tx_push[g]),
            .pop   (tx_pop[g]),
            .din   (DATA_IN[DW-1:0]),
            .full  (tx_full[g]),
            .empty (tx_empty[g]),
            .head  (tx_head[g])
         );
         assign TX_DATA[g*DW +: DW] = tx_head[g];
      end
      if (BUS_W > DW) begin : g_unused
         logic unused_data_in_hi;
         assign unused_data_in_hi = ^DATA_IN[BUS_W-1:DW];
      end
   endgenerate

   // RX capture/clear and sticky flag update; a set in the same cycle beats an IOS clear
   always_comb begin
      rx_data_d = rx_data_q;
      rx_full_d = rx_full_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      for (int c = 0; c < NCH; c++) begin
         if (RX_VALID[c] && !rx_full_q[c]) begin
            rx_full_d[c] = 1'b1;
            rx_data_d[c] = RX_DATA[c*DW +: DW];
         end else if (rd_stb && sel[c]) begin
            rx_full_d[c] = 1'b0;
         end
         ovf_d[c] = (IOW & sel[c] & tx_full[c])
                  | (ovf_q[c] & ~(st_stb & sel[c]));
         unf_d[c] = (rd_stb & sel[c] & ~rx_full_q[c])
                  | (unf_q[c] & ~(st_stb & sel[c]));
      end
   end

   // Per-channel RX and flag registers
   always_ff @(posedge CLK or posedge AR) begin
      if (AR) begin
         rx_data_q <= '{default: '0};
         rx_full_q <= '0;
         ovf_q     <= '0;
         unf_q     <= '0;
      end else begin
         rx_data_q <= rx_data_d;
         rx_full_q <= rx_full_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   // Combinational bus read mux; an empty RX register reads as zero
   always_comb begin
      rd_byte = '0;
      status  = '0;
      for (int c = 0; c < NCH; c++) begin
         if (sel[c]) begin
            rd_byte        = rx_full_q[c] ? rx_data_q[c] : '0;
            status[ST_TXE] = tx_empty[c];
            status[ST_TXF] = tx_full[c];
            status[ST_RXF] = rx_full_q[c];
            status[ST_OVF] = ovf_q[c];
            status[ST_UNF] = unf_q[c];
         end
      end
      DATA_OE  = (IOR | IOS) & ~AR;
      DATA_OUT = '0;
      if (DATA_OE) begin
         DATA_OUT = IOR ? BUS_W'(rd_byte) : BUS_W'(status);
      end
   end

endmodule : scp_io_hub
